// File: rtl/seq_det_event_logger.sv
// seq_det_event_logger
// Turns the held 4-bit code of the 1001/1110 sequence detector into single-cycle
// events. Events are counted per pattern and timestamped, and the resulting
// records are queued in a first-word-fall-through FIFO for a valid/ready reader.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   det_code     detector code; 4'b0000 means no detection
//   clr          synchronous clear of counters, FIFO and drop/overflow state
//   evt_valid    FIFO head holds a record
//   evt_ready    reader accepts the head this cycle
//   evt_data     head record {type, timestamp}; type 0 = CODE_A, 1 = CODE_B
//   cnt_a/cnt_b  saturating per-pattern event counters
//   drop_cnt     saturating count of events lost to a full FIFO
//   overflow     sticky flag: at least one event was dropped
//   fifo_level   current FIFO occupancy
module seq_det_event_logger #(
  parameter int         CNT_W  = 8,
  parameter int         TS_W   = 12,
  parameter int         DEPTH  = 8,
  parameter logic [3:0] CODE_A = 4'b1001,
  parameter logic [3:0] CODE_B = 4'b1110
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [3:0]                 det_code,
  input  logic                       clr,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [TS_W:0]              evt_data,
  output logic [CNT_W-1:0]           cnt_a,
  output logic [CNT_W-1:0]           cnt_b,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [3:0]       code_q_r;
  logic [TS_W-1:0]  ts_r;
  logic [TS_W:0]    mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic [CNT_W-1:0] cnt_a_r;
  logic [CNT_W-1:0] cnt_b_r;
  logic [CNT_W-1:0] drop_cnt_r;
  logic             overflow_r;

  logic             ev_a_s;
  logic             ev_b_s;
  logic             ev_s;
  logic             pop_s;
  logic             push_s;
  logic             drop_s;
  logic [TS_W:0]    rec_s;

  // Saturating increment shared by all counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Edge detection on the code level plus FIFO push/pop/drop decisions.
  always_comb begin
    ev_a_s = 1'b0;
    ev_b_s = 1'b0;
    pop_s  = 1'b0;
    push_s = 1'b0;
    drop_s = 1'b0;
    ev_a_s = (det_code == CODE_A) && (code_q_r != CODE_A);
    ev_b_s = (det_code == CODE_B) && (code_q_r != CODE_B);
    ev_s   = ev_a_s || ev_b_s;
    rec_s  = {ev_b_s, ts_r};
    // A clear cycle voids both the pop and any event seen in it.
    if (clr) begin
      pop_s  = 1'b0;
      push_s = 1'b0;
      drop_s = 1'b0;
    end else begin
      pop_s  = (level_r != {LVL_W{1'b0}}) && evt_ready;
      push_s = ev_s && ((level_r < LVL_W'(DEPTH)) || pop_s);
      drop_s = ev_s && !push_s;
    end
  end

  // Previous code and free-running timestamp; clr intentionally leaves these alone
  // so that a code held across clr does not re-trigger.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q_r <= 4'b0000;
      ts_r     <= {TS_W{1'b0}};
    end else begin
      code_q_r <= det_code;
      ts_r     <= ts_r + {{(TS_W-1){1'b0}}, 1'b1};
    end
  end

  // Record storage; reset so that the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {(TS_W+1){1'b0}};
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= rec_s;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else if (clr) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + {{(LVL_W-1){1'b0}}, 1'b1};
        2'b01:   level_r <= level_r - {{(LVL_W-1){1'b0}}, 1'b1};
        default: level_r <= level_r;
      endcase
    end
  end

  // Pattern counters, drop counter and sticky overflow; dropped events still count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a_r    <= {CNT_W{1'b0}};
      cnt_b_r    <= {CNT_W{1'b0}};
      drop_cnt_r <= {CNT_W{1'b0}};
      overflow_r <= 1'b0;
    end else if (clr) begin
      cnt_a_r    <= {CNT_W{1'b0}};
      cnt_b_r    <= {CNT_W{1'b0}};
      drop_cnt_r <= {CNT_W{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (ev_a_s) begin
        cnt_a_r <= sat_inc(cnt_a_r);
      end
      if (ev_b_s) begin
        cnt_b_r <= sat_inc(cnt_b_r);
      end
      if (drop_s) begin
        drop_cnt_r <= sat_inc(drop_cnt_r);
        overflow_r <= 1'b1;
      end
    end
  end

  assign evt_valid  = (level_r != {LVL_W{1'b0}});
  assign evt_data   = mem_r[rd_ptr_r];
  assign cnt_a      = cnt_a_r;
  assign cnt_b      = cnt_b_r;
  assign drop_cnt   = drop_cnt_r;
  assign overflow   = overflow_r;
  assign fifo_level = level_r;

endmodule
